serial_pattern_gen: RTL and testbench

Serial bit-stream generator that drives the single-bit `x` input of the team's Mealy sequence detectors. It captures a pattern word with a length and repeat count on a `start` request. It then emits the pattern LSB-first, one bit per clock, with a valid strobe and a stall input. Its purpose is to replace hand-written `x` stimulus and to act as the transmit end of the serial detector interface.

---
 rtl/serial_pattern_gen.sv | 98 +++++++++
 tb/tb_serial_pattern_gen.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_pattern_gen.sv
// serial_pattern_gen: LSB-first serial pattern source with repeat and stall.
// Feeds the single-bit x input of the sequence detectors.
module serial_pattern_gen #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 3,
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [REP_W-1:0] reps,
  input  logic             hold,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done,
  output logic [1:0]       stateReg
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    SHIFT = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic [REP_W-1:0] reps_q;
  logic [WIDTH-1:0] shreg;
  logic [LEN_W-1:0] bitcnt;
  logic [REP_W-1:0] repcnt;
  logic [LEN_W-1:0] len_c;

  // lengths beyond the register width send the whole word
  assign len_c = (32'(len) >= WIDTH) ? LEN_W'(WIDTH - 1) : len;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      pat_q  <= '0;
      len_q  <= '0;
      reps_q <= '0;
      shreg  <= '0;
      bitcnt <= '0;
      repcnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            pat_q  <= pattern;
            len_q  <= len_c;
            reps_q <= reps;
            state  <= LOAD;
          end
        end
        LOAD: begin
          shreg  <= pat_q;
          bitcnt <= len_q;
          repcnt <= reps_q;
          state  <= SHIFT;
        end
        SHIFT: begin
          if (!hold) begin
            if (bitcnt != '0) begin
              shreg  <= shreg >> 1;
              bitcnt <= bitcnt - LEN_W'(1);
            end else if (repcnt != '0) begin
              shreg  <= pat_q;
              bitcnt <= len_q;
              repcnt <= repcnt - REP_W'(1);
            end else begin
              shreg  <= shreg >> 1;
              bitcnt <= bitcnt - LEN_W'(1);
              state  <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign x        = (state == SHIFT) ? shreg[0] : 1'b0;
  assign x_valid  = (state == SHIFT) && !hold;
  assign busy     = (state == LOAD) || (state == SHIFT);
  assign done     = (state == DONE);
  assign stateReg = state;

endmodule

// File: tb/tb_serial_pattern_gen.sv
// tb_serial_pattern_gen: directed bench for serial_pattern_gen.
// Streams are collected per request and compared with hand-computed words.
module tb_serial_pattern_gen;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] pattern;
  logic [2:0] len;
  logic [3:0] reps;
  logic       hold;
  logic       x;
  logic       x_valid;
  logic       busy;
  logic       done;
  logic [1:0] stateReg;

  int checks;
  int failures;

  int          nb;
  logic [31:0] bits;
  int          bc;
  int          dc;
  int          dcyc;
  int          hn;
  logic [31:0] hx;
  logic        ended;

  serial_pattern_gen dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .pattern  (pattern),
    .len      (len),
    .reps     (reps),
    .hold     (hold),
    .x        (x),
    .x_valid  (x_valid),
    .busy     (busy),
    .done     (done),
    .stateReg (stateReg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [7:0] p, input logic [2:0] l,
                    input logic [3:0] r);
    pattern = p;
    len     = l;
    reps    = r;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  // walk one request from LOAD back to IDLE, logging what comes out
  task automatic run(input int maxc, input int hold_c, input int poke_c);
    nb = 0; bits = '0; bc = 0; dc = 0; dcyc = -1; hn = 0; hx = '0;
    ended = 1'b0;
    for (int c = 0; c < maxc; c++) begin
      hold = (c == hold_c) || (c == hold_c + 1);
      if (c == poke_c) begin
        start   = 1'b1;
        pattern = 8'hFF;
      end else begin
        start = 1'b0;
      end
      #1;
      if (busy) bc++;
      if (x_valid) begin
        bits[nb] = x;
        nb++;
      end
      if (hold && stateReg == 2'b10) begin
        hx[hn] = x;
        hn++;
      end
      if (done) begin
        dc++;
        dcyc = c;
      end
      if (c > 0 && stateReg == 2'b00) begin
        ended = 1'b1;
        break;
      end
      tick();
    end
    hold  = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b0; start = 1'b1; hold = 1'b0;
    pattern = 8'h00; len = 3'd0; reps = 4'd0;

    tick();
    tick();
    chk("rst_state", 32'(stateReg), 32'h0);
    chk("rst_outs", {28'h0, x, x_valid, busy, done}, 32'h0);

    start = 1'b0;
    rst   = 1'b1;
    tick();
    tick();
    chk("idle_after_rst", 32'(stateReg), 32'h0);
    chk("idle_busy", 32'(busy), 32'h0);

    // single pass 0x0D, 4 bits
    go(8'h0D, 3'd3, 4'd0);
    chk("load_state", 32'(stateReg), 32'h1);
    chk("load_xvalid", 32'(x_valid), 32'h0);
    run(40, -10, -10);
    chk("sp_end", 32'(ended), 32'h1);
    chk("sp_nbits", nb, 4);
    chk("sp_bits", bits, 32'hD);
    chk("sp_busy", bc, 5);
    chk("sp_done_cnt", dc, 1);
    chk("sp_done_cyc", dcyc, 5);

    // two passes of 6 bits from 0x17
    go(8'h17, 3'd5, 4'd1);
    run(60, -10, -10);
    chk("rep_end", 32'(ended), 32'h1);
    chk("rep_nbits", nb, 12);
    chk("rep_bits", bits, 32'h5D7);
    chk("rep_busy", bc, 13);
    chk("rep_done_cyc", dcyc, 13);

    // stall for 2 cycles after the 2nd bit
    go(8'h0D, 3'd3, 4'd0);
    run(40, 3, -10);
    chk("hold_nbits", nb, 4);
    chk("hold_bits", bits, 32'hD);
    chk("hold_n", hn, 2);
    chk("hold_x", hx, 32'h3);
    chk("hold_done_cyc", dcyc, 7);
    chk("hold_busy", bc, 7);

    // start and pattern poked during SHIFT
    go(8'h0D, 3'd3, 4'd0);
    run(40, -10, 2);
    chk("poke_bits", bits, 32'hD);
    chk("poke_nbits", nb, 4);
    chk("poke_done_cnt", dc, 1);
    tick();
    chk("poke_idle", 32'(stateReg), 32'h0);

    // single-bit passes
    go(8'h01, 3'd0, 4'd2);
    run(40, -10, -10);
    chk("len0_nbits", nb, 3);
    chk("len0_bits", bits, 32'h7);

    // full word
    go(8'hA5, 3'd7, 4'd0);
    run(40, -10, -10);
    chk("full_nbits", nb, 8);
    chk("full_bits", bits, 32'hA5);

    // asynchronous abort during the 3rd bit
    go(8'h0D, 3'd3, 4'd0);
    tick();
    tick();
    tick();
    chk("abort_pre", {30'h0, x, x_valid}, 32'h3);
    #2;
    rst = 1'b0;
    #1;
    chk("abort_state", 32'(stateReg), 32'h0);
    chk("abort_outs", {28'h0, x, x_valid, busy, done}, 32'h0);
    tick();
    rst = 1'b1;
    tick();
    chk("abort_idle", 32'(stateReg), 32'h0);
    go(8'h0D, 3'd3, 4'd0);
    run(40, -10, -10);
    chk("abort_nbits", nb, 4);
    chk("abort_bits", bits, 32'hD);
    chk("abort_done_cnt", dc, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
